control_unit: RTL and testbench

//  Hardwired MiniSRC control sequencer; drives every control input of DataPath.

---
 rtl/control_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired MiniSRC control sequencer: fetch T0-T2, then a per-opcode execute sequence.
// Outputs are Moore-decoded from the current step and the IR opcode class.
module control_unit #(
    parameter int unsigned OPW   = 5,
    parameter int unsigned STEPW = 3
) (
    input  logic           i_clock,
    input  logic           i_clear,
    input  logic [OPW-1:0] i_ir_op,
    input  logic           i_branch_out,
    output logic           o_run,
    output logic           o_pc_out,
    output logic           o_zlow_out,
    output logic           o_zhigh_out,
    output logic           o_mdr_out,
    output logic           o_hi_out,
    output logic           o_lo_out,
    output logic           o_in_port_out,
    output logic           o_c_out,
    output logic           o_ba_out,
    output logic           o_r_out,
    output logic           o_mar_in,
    output logic           o_z_in,
    output logic           o_pc_in,
    output logic           o_mdr_in,
    output logic           o_ir_in,
    output logic           o_y_in,
    output logic           o_hi_in,
    output logic           o_lo_in,
    output logic           o_con_in,
    output logic           o_out_port_in,
    output logic           o_r_in,
    output logic           o_gra,
    output logic           o_grb,
    output logic           o_grc,
    output logic           o_inc_pc,
    output logic           o_read,
    output logic           o_write,
    output logic           o_add,
    output logic           o_sub,
    output logic           o_and,
    output logic           o_or,
    output logic           o_shr,
    output logic           o_shra,
    output logic           o_shl,
    output logic           o_ror,
    output logic           o_rol,
    output logic           o_mul,
    output logic           o_div,
    output logic           o_neg,
    output logic           o_not
);

    typedef enum logic [1:0] {ModeRst, ModeHalt, ModeRun} mode_e;

    typedef enum logic [3:0] {
        ClsRType, ClsImm, ClsMulDiv, ClsNegNot, ClsLd, ClsLdi, ClsSt, ClsBr,
        ClsJr, ClsJal, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsNop, ClsHalt
    } class_e;

    localparam logic [STEPW-1:0] StepT0 = STEPW'(0);
    localparam logic [STEPW-1:0] StepT1 = STEPW'(1);
    localparam logic [STEPW-1:0] StepT2 = STEPW'(2);
    localparam logic [STEPW-1:0] StepT3 = STEPW'(3);
    localparam logic [STEPW-1:0] StepT4 = STEPW'(4);
    localparam logic [STEPW-1:0] StepT5 = STEPW'(5);
    localparam logic [STEPW-1:0] StepT6 = STEPW'(6);
    localparam logic [STEPW-1:0] StepT7 = STEPW'(7);

    localparam logic [OPW-1:0] OpLd   = OPW'(5'b00000);
    localparam logic [OPW-1:0] OpLdi  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OpSt   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OpAdd  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OpSub  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OpAnd  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OpOr   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OpShr  = OPW'(5'b00111);
    localparam logic [OPW-1:0] OpShra = OPW'(5'b01000);
    localparam logic [OPW-1:0] OpShl  = OPW'(5'b01001);
    localparam logic [OPW-1:0] OpRor  = OPW'(5'b01010);
    localparam logic [OPW-1:0] OpRol  = OPW'(5'b01011);
    localparam logic [OPW-1:0] OpAddi = OPW'(5'b01100);
    localparam logic [OPW-1:0] OpAndi = OPW'(5'b01101);
    localparam logic [OPW-1:0] OpOri  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OpMul  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OpDiv  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OpNeg  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OpNot  = OPW'(5'b10010);
    localparam logic [OPW-1:0] OpBr   = OPW'(5'b10011);
    localparam logic [OPW-1:0] OpJr   = OPW'(5'b10100);
    localparam logic [OPW-1:0] OpJal  = OPW'(5'b10101);
    localparam logic [OPW-1:0] OpIn   = OPW'(5'b10110);
    localparam logic [OPW-1:0] OpOut  = OPW'(5'b10111);
    localparam logic [OPW-1:0] OpMfhi = OPW'(5'b11000);
    localparam logic [OPW-1:0] OpMflo = OPW'(5'b11001);
    localparam logic [OPW-1:0] OpHalt = OPW'(5'b11011);

    localparam int unsigned AluAdd  = 0;
    localparam int unsigned AluSub  = 1;
    localparam int unsigned AluAnd  = 2;
    localparam int unsigned AluOr   = 3;
    localparam int unsigned AluShr  = 4;
    localparam int unsigned AluShra = 5;
    localparam int unsigned AluShl  = 6;
    localparam int unsigned AluRor  = 7;
    localparam int unsigned AluRol  = 8;
    localparam int unsigned AluMul  = 9;
    localparam int unsigned AluDiv  = 10;
    localparam int unsigned AluNeg  = 11;
    localparam int unsigned AluNot  = 12;

    mode_e            r_mode, w_mode_d;
    logic [STEPW-1:0] r_step, w_step_d;
    class_e           w_class;
    logic [STEPW-1:0] w_last;
    logic [12:0]      w_op_alu;
    logic [12:0]      w_alu;

    always_comb begin
        w_class = ClsNop;
        case (i_ir_op)
            OpLd:                                  w_class = ClsLd;
            OpLdi:                                 w_class = ClsLdi;
            OpSt:                                  w_class = ClsSt;
            OpAdd, OpSub, OpAnd, OpOr, OpShr,
            OpShra, OpShl, OpRor, OpRol:           w_class = ClsRType;
            OpAddi, OpAndi, OpOri:                 w_class = ClsImm;
            OpMul, OpDiv:                          w_class = ClsMulDiv;
            OpNeg, OpNot:                          w_class = ClsNegNot;
            OpBr:                                  w_class = ClsBr;
            OpJr:                                  w_class = ClsJr;
            OpJal:                                 w_class = ClsJal;
            OpIn:                                  w_class = ClsIn;
            OpOut:                                 w_class = ClsOut;
            OpMfhi:                                w_class = ClsMfhi;
            OpMflo:                                w_class = ClsMflo;
            OpHalt:                                w_class = ClsHalt;
            default:                               w_class = ClsNop;
        endcase
    end

    always_comb begin
        w_op_alu = '0;
        case (i_ir_op)
            OpAdd, OpAddi: w_op_alu[AluAdd]  = 1'b1;
            OpSub:         w_op_alu[AluSub]  = 1'b1;
            OpAnd, OpAndi: w_op_alu[AluAnd]  = 1'b1;
            OpOr, OpOri:   w_op_alu[AluOr]   = 1'b1;
            OpShr:         w_op_alu[AluShr]  = 1'b1;
            OpShra:        w_op_alu[AluShra] = 1'b1;
            OpShl:         w_op_alu[AluShl]  = 1'b1;
            OpRor:         w_op_alu[AluRor]  = 1'b1;
            OpRol:         w_op_alu[AluRol]  = 1'b1;
            OpMul:         w_op_alu[AluMul]  = 1'b1;
            OpDiv:         w_op_alu[AluDiv]  = 1'b1;
            OpNeg:         w_op_alu[AluNeg]  = 1'b1;
            OpNot:         w_op_alu[AluNot]  = 1'b1;
            default:       w_op_alu = '0;
        endcase
    end

    // Final step of each class; nop/halt end after fetch.
    always_comb begin
        w_last = StepT3;
        case (w_class)
            ClsRType, ClsImm, ClsLdi: w_last = StepT5;
            ClsMulDiv, ClsBr:         w_last = StepT6;
            ClsNegNot, ClsJal:        w_last = StepT4;
            ClsLd, ClsSt:             w_last = StepT7;
            ClsNop, ClsHalt:          w_last = StepT2;
            default:                  w_last = StepT3;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_mode <= ModeRst;
            r_step <= StepT0;
        end else begin
            r_mode <= w_mode_d;
            r_step <= w_step_d;
        end
    end

    always_comb begin
        w_mode_d = r_mode;
        w_step_d = r_step;
        case (r_mode)
            ModeRst: begin
                w_mode_d = ModeRun;
                w_step_d = StepT0;
            end
            ModeRun: begin
                // >= keeps the counter from running past T7 even on a stale opcode
                if (r_step >= w_last || r_step == StepT7) begin
                    w_step_d = StepT0;
                    if (w_class == ClsHalt) begin
                        w_mode_d = ModeHalt;
                    end
                end else begin
                    w_step_d = r_step + 1'b1;
                end
            end
            default: begin
                w_mode_d = ModeHalt;
                w_step_d = StepT0;
            end
        endcase
    end

    always_comb begin
        o_run = 1'b0;
        o_pc_out = 1'b0; o_zlow_out = 1'b0; o_zhigh_out = 1'b0; o_mdr_out = 1'b0;
        o_hi_out = 1'b0; o_lo_out = 1'b0; o_in_port_out = 1'b0; o_c_out = 1'b0;
        o_ba_out = 1'b0; o_r_out = 1'b0;
        o_mar_in = 1'b0; o_z_in = 1'b0; o_pc_in = 1'b0; o_mdr_in = 1'b0; o_ir_in = 1'b0;
        o_y_in = 1'b0; o_hi_in = 1'b0; o_lo_in = 1'b0; o_con_in = 1'b0;
        o_out_port_in = 1'b0; o_r_in = 1'b0;
        o_gra = 1'b0; o_grb = 1'b0; o_grc = 1'b0; o_inc_pc = 1'b0;
        o_read = 1'b0; o_write = 1'b0;
        w_alu = '0;
        if (r_mode == ModeRun) begin
            o_run = 1'b1;
            case (r_step)
                StepT0: begin
                    o_pc_out = 1'b1; o_mar_in = 1'b1; o_inc_pc = 1'b1; o_z_in = 1'b1;
                end
                StepT1: begin
                    o_zlow_out = 1'b1; o_pc_in = 1'b1; o_read = 1'b1; o_mdr_in = 1'b1;
                end
                StepT2: begin
                    o_mdr_out = 1'b1; o_ir_in = 1'b1;
                end
                default: begin
                    case (w_class)
                        ClsRType, ClsImm: begin
                            case (r_step)
                                StepT3: begin o_grb = 1'b1; o_r_out = 1'b1; o_y_in = 1'b1; end
                                StepT4: begin
                                    if (w_class == ClsRType) begin
                                        o_grc = 1'b1; o_r_out = 1'b1;
                                    end else begin
                                        o_c_out = 1'b1;
                                    end
                                    w_alu = w_op_alu; o_z_in = 1'b1;
                                end
                                StepT5: begin o_zlow_out = 1'b1; o_gra = 1'b1; o_r_in = 1'b1; end
                                default: ;
                            endcase
                        end
                        ClsMulDiv: begin
                            case (r_step)
                                StepT3: begin o_gra = 1'b1; o_r_out = 1'b1; o_y_in = 1'b1; end
                                StepT4: begin
                                    o_grb = 1'b1; o_r_out = 1'b1; w_alu = w_op_alu; o_z_in = 1'b1;
                                end
                                StepT5: begin o_zlow_out = 1'b1; o_lo_in = 1'b1; end
                                StepT6: begin o_zhigh_out = 1'b1; o_hi_in = 1'b1; end
                                default: ;
                            endcase
                        end
                        ClsNegNot: begin
                            case (r_step)
                                StepT3: begin
                                    o_grb = 1'b1; o_r_out = 1'b1; w_alu = w_op_alu; o_z_in = 1'b1;
                                end
                                StepT4: begin o_zlow_out = 1'b1; o_gra = 1'b1; o_r_in = 1'b1; end
                                default: ;
                            endcase
                        end
                        ClsLd, ClsLdi, ClsSt: begin
                            case (r_step)
                                StepT3: begin o_grb = 1'b1; o_ba_out = 1'b1; o_y_in = 1'b1; end
                                StepT4: begin o_c_out = 1'b1; w_alu[AluAdd] = 1'b1; o_z_in = 1'b1; end
                                StepT5: begin
                                    o_zlow_out = 1'b1;
                                    if (w_class == ClsLdi) begin
                                        o_gra = 1'b1; o_r_in = 1'b1;
                                    end else begin
                                        o_mar_in = 1'b1;
                                    end
                                end
                                StepT6: begin
                                    if (w_class == ClsLd) begin
                                        o_read = 1'b1; o_mdr_in = 1'b1;
                                    end else if (w_class == ClsSt) begin
                                        o_gra = 1'b1; o_r_out = 1'b1; o_mdr_in = 1'b1;
                                    end
                                end
                                StepT7: begin
                                    if (w_class == ClsLd) begin
                                        o_mdr_out = 1'b1; o_gra = 1'b1; o_r_in = 1'b1;
                                    end else if (w_class == ClsSt) begin
                                        o_write = 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        ClsBr: begin
                            case (r_step)
                                StepT3: begin o_gra = 1'b1; o_r_out = 1'b1; o_con_in = 1'b1; end
                                StepT4: begin o_pc_out = 1'b1; o_y_in = 1'b1; end
                                StepT5: begin o_c_out = 1'b1; w_alu[AluAdd] = 1'b1; o_z_in = 1'b1; end
                                StepT6: begin
                                    o_zlow_out = i_branch_out; o_pc_in = i_branch_out;
                                end
                                default: ;
                            endcase
                        end
                        ClsJr: begin
                            if (r_step == StepT3) begin
                                o_gra = 1'b1; o_r_out = 1'b1; o_pc_in = 1'b1;
                            end
                        end
                        ClsJal: begin
                            if (r_step == StepT3) begin
                                o_pc_out = 1'b1; o_grb = 1'b1; o_r_in = 1'b1;
                            end else if (r_step == StepT4) begin
                                o_gra = 1'b1; o_r_out = 1'b1; o_pc_in = 1'b1;
                            end
                        end
                        ClsIn: begin
                            if (r_step == StepT3) begin
                                o_in_port_out = 1'b1; o_gra = 1'b1; o_r_in = 1'b1;
                            end
                        end
                        ClsOut: begin
                            if (r_step == StepT3) begin
                                o_gra = 1'b1; o_r_out = 1'b1; o_out_port_in = 1'b1;
                            end
                        end
                        ClsMfhi: begin
                            if (r_step == StepT3) begin
                                o_hi_out = 1'b1; o_gra = 1'b1; o_r_in = 1'b1;
                            end
                        end
                        ClsMflo: begin
                            if (r_step == StepT3) begin
                                o_lo_out = 1'b1; o_gra = 1'b1; o_r_in = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign o_add  = w_alu[AluAdd];
    assign o_sub  = w_alu[AluSub];
    assign o_and  = w_alu[AluAnd];
    assign o_or   = w_alu[AluOr];
    assign o_shr  = w_alu[AluShr];
    assign o_shra = w_alu[AluShra];
    assign o_shl  = w_alu[AluShl];
    assign o_ror  = w_alu[AluRor];
    assign o_rol  = w_alu[AluRol];
    assign o_mul  = w_alu[AluMul];
    assign o_div  = w_alu[AluDiv];
    assign o_neg  = w_alu[AluNeg];
    assign o_not  = w_alu[AluNot];

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: every step's full control word is compared against a
// hand-built expected word made from one-bit masks.
module tb_control_unit;

    localparam logic [40:0] PC_OUT    = 41'd1 << 0;
    localparam logic [40:0] ZLOW_OUT  = 41'd1 << 1;
    localparam logic [40:0] ZHIGH_OUT = 41'd1 << 2;
    localparam logic [40:0] MDR_OUT   = 41'd1 << 3;
    localparam logic [40:0] HI_OUT    = 41'd1 << 4;
    localparam logic [40:0] LO_OUT    = 41'd1 << 5;
    localparam logic [40:0] INP_OUT   = 41'd1 << 6;
    localparam logic [40:0] C_OUT     = 41'd1 << 7;
    localparam logic [40:0] BA_OUT    = 41'd1 << 8;
    localparam logic [40:0] R_OUT     = 41'd1 << 9;
    localparam logic [40:0] MAR_IN    = 41'd1 << 10;
    localparam logic [40:0] Z_IN      = 41'd1 << 11;
    localparam logic [40:0] PC_IN     = 41'd1 << 12;
    localparam logic [40:0] MDR_IN    = 41'd1 << 13;
    localparam logic [40:0] IR_IN     = 41'd1 << 14;
    localparam logic [40:0] Y_IN      = 41'd1 << 15;
    localparam logic [40:0] HI_IN     = 41'd1 << 16;
    localparam logic [40:0] LO_IN     = 41'd1 << 17;
    localparam logic [40:0] CON_IN    = 41'd1 << 18;
    localparam logic [40:0] OUTP_IN   = 41'd1 << 19;
    localparam logic [40:0] R_IN      = 41'd1 << 20;
    localparam logic [40:0] GRA       = 41'd1 << 21;
    localparam logic [40:0] GRB       = 41'd1 << 22;
    localparam logic [40:0] GRC       = 41'd1 << 23;
    localparam logic [40:0] INC_PC    = 41'd1 << 24;
    localparam logic [40:0] READ      = 41'd1 << 25;
    localparam logic [40:0] WRITE     = 41'd1 << 26;
    localparam logic [40:0] ADD       = 41'd1 << 27;
    localparam logic [40:0] SUB       = 41'd1 << 28;
    localparam logic [40:0] AND_OP    = 41'd1 << 29;
    localparam logic [40:0] MUL       = 41'd1 << 36;
    localparam logic [40:0] NEG       = 41'd1 << 38;
    localparam logic [40:0] RUN       = 41'd1 << 40;

    localparam logic [40:0] F0 = RUN | PC_OUT | MAR_IN | INC_PC | Z_IN;
    localparam logic [40:0] F1 = RUN | ZLOW_OUT | PC_IN | READ | MDR_IN;
    localparam logic [40:0] F2 = RUN | MDR_OUT | IR_IN;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic [4:0] ir_op = 5'b00000;
    logic       branch = 1'b0;

    logic run, pc_out, zlow_out, zhigh_out, mdr_out, hi_out, lo_out, in_port_out, c_out;
    logic ba_out, r_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, con_in;
    logic out_port_in, r_in, gra, grb, grc, inc_pc, rd, wr;
    logic op_add, op_sub, op_and, op_or, op_shr, op_shra, op_shl, op_ror, op_rol;
    logic op_mul, op_div, op_neg, op_not;
    logic [40:0] ctl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    control_unit #(.OPW(5), .STEPW(3)) dut (
        .i_clock(clk), .i_clear(clear), .i_ir_op(ir_op), .i_branch_out(branch),
        .o_run(run), .o_pc_out(pc_out), .o_zlow_out(zlow_out), .o_zhigh_out(zhigh_out),
        .o_mdr_out(mdr_out), .o_hi_out(hi_out), .o_lo_out(lo_out),
        .o_in_port_out(in_port_out), .o_c_out(c_out), .o_ba_out(ba_out), .o_r_out(r_out),
        .o_mar_in(mar_in), .o_z_in(z_in), .o_pc_in(pc_in), .o_mdr_in(mdr_in),
        .o_ir_in(ir_in), .o_y_in(y_in), .o_hi_in(hi_in), .o_lo_in(lo_in),
        .o_con_in(con_in), .o_out_port_in(out_port_in), .o_r_in(r_in),
        .o_gra(gra), .o_grb(grb), .o_grc(grc), .o_inc_pc(inc_pc), .o_read(rd), .o_write(wr),
        .o_add(op_add), .o_sub(op_sub), .o_and(op_and), .o_or(op_or), .o_shr(op_shr),
        .o_shra(op_shra), .o_shl(op_shl), .o_ror(op_ror), .o_rol(op_rol),
        .o_mul(op_mul), .o_div(op_div), .o_neg(op_neg), .o_not(op_not)
    );

    assign ctl = {run, op_not, op_neg, op_div, op_mul, op_rol, op_ror, op_shl, op_shra,
                  op_shr, op_or, op_and, op_sub, op_add, wr, rd, inc_pc, grc, grb, gra,
                  r_in, out_port_in, con_in, lo_in, hi_in, y_in, ir_in, mdr_in, pc_in,
                  z_in, mar_in, r_out, ba_out, c_out, in_port_out, lo_out, hi_out,
                  mdr_out, zhigh_out, zlow_out, pc_out};

    task automatic check_eq(input string tag, input logic [40:0] got, input logic [40:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and compare the control word mid-cycle.
    task automatic step(input string tag, input logic [40:0] exp);
        @(posedge clk);
        @(negedge clk);
        check_eq(tag, ctl, exp);
    endtask

    // Fetch; the opcode changes only after T0 so the previous instruction is not disturbed.
    task automatic fetch(input string tag, input logic [4:0] op, input logic br);
        step({tag, "_t0"}, F0);
        ir_op  = op;
        branch = br;
        step({tag, "_t1"}, F1);
        step({tag, "_t2"}, F2);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset", ctl, '0);
        clear = 1'b0;

        // add
        fetch("add", 5'b00011, 1'b0);
        step("add_t3", RUN | GRB | R_OUT | Y_IN);
        step("add_t4", RUN | GRC | R_OUT | ADD | Z_IN);
        step("add_t5", RUN | ZLOW_OUT | GRA | R_IN);

        // sub
        fetch("sub", 5'b00100, 1'b0);
        step("sub_t3", RUN | GRB | R_OUT | Y_IN);
        step("sub_t4", RUN | GRC | R_OUT | SUB | Z_IN);
        step("sub_t5", RUN | ZLOW_OUT | GRA | R_IN);

        // andi
        fetch("andi", 5'b01101, 1'b0);
        step("andi_t3", RUN | GRB | R_OUT | Y_IN);
        step("andi_t4", RUN | C_OUT | AND_OP | Z_IN);
        step("andi_t5", RUN | ZLOW_OUT | GRA | R_IN);

        // ld, full 8 cycles
        fetch("ld", 5'b00000, 1'b0);
        step("ld_t3", RUN | GRB | BA_OUT | Y_IN);
        step("ld_t4", RUN | C_OUT | ADD | Z_IN);
        step("ld_t5", RUN | ZLOW_OUT | MAR_IN);
        step("ld_t6", RUN | READ | MDR_IN);
        step("ld_t7", RUN | MDR_OUT | GRA | R_IN);

        // st
        fetch("st", 5'b00010, 1'b0);
        step("st_t3", RUN | GRB | BA_OUT | Y_IN);
        step("st_t4", RUN | C_OUT | ADD | Z_IN);
        step("st_t5", RUN | ZLOW_OUT | MAR_IN);
        step("st_t6", RUN | GRA | R_OUT | MDR_IN);
        step("st_t7", RUN | WRITE);

        // br not taken, then taken
        fetch("brn", 5'b10011, 1'b0);
        step("brn_t3", RUN | GRA | R_OUT | CON_IN);
        step("brn_t4", RUN | PC_OUT | Y_IN);
        step("brn_t5", RUN | C_OUT | ADD | Z_IN);
        step("brn_t6", RUN);
        fetch("brt", 5'b10011, 1'b1);
        step("brt_t3", RUN | GRA | R_OUT | CON_IN);
        step("brt_t4", RUN | PC_OUT | Y_IN);
        step("brt_t5", RUN | C_OUT | ADD | Z_IN);
        step("brt_t6", RUN | ZLOW_OUT | PC_IN);

        // mul
        fetch("mul", 5'b01111, 1'b0);
        step("mul_t3", RUN | GRA | R_OUT | Y_IN);
        step("mul_t4", RUN | GRB | R_OUT | MUL | Z_IN);
        step("mul_t5", RUN | ZLOW_OUT | LO_IN);
        step("mul_t6", RUN | ZHIGH_OUT | HI_IN);

        // neg
        fetch("neg", 5'b10001, 1'b0);
        step("neg_t3", RUN | GRB | R_OUT | NEG | Z_IN);
        step("neg_t4", RUN | ZLOW_OUT | GRA | R_IN);

        // single/double step instructions
        fetch("jal", 5'b10101, 1'b0);
        step("jal_t3", RUN | PC_OUT | GRB | R_IN);
        step("jal_t4", RUN | GRA | R_OUT | PC_IN);
        fetch("jr", 5'b10100, 1'b0);
        step("jr_t3", RUN | GRA | R_OUT | PC_IN);
        fetch("in", 5'b10110, 1'b0);
        step("in_t3", RUN | INP_OUT | GRA | R_IN);
        fetch("out", 5'b10111, 1'b0);
        step("out_t3", RUN | GRA | R_OUT | OUTP_IN);
        fetch("mfhi", 5'b11000, 1'b0);
        step("mfhi_t3", RUN | HI_OUT | GRA | R_IN);
        fetch("mflo", 5'b11001, 1'b0);
        step("mflo_t3", RUN | LO_OUT | GRA | R_IN);

        // nop and an undefined opcode return to T0 straight after T2
        fetch("nop", 5'b11010, 1'b0);
        fetch("undef", 5'b11110, 1'b0);

        // Clear asserted mid-T5 of ld aborts at once; first edge after release is T0
        fetch("lda", 5'b00000, 1'b0);
        step("lda_t3", RUN | GRB | BA_OUT | Y_IN);
        step("lda_t4", RUN | C_OUT | ADD | Z_IN);
        step("lda_t5", RUN | ZLOW_OUT | MAR_IN);
        #2 clear = 1'b1;
        #1 check_eq("lda_abort", ctl, '0);
        @(negedge clk);
        check_eq("lda_held", ctl, '0);
        clear = 1'b0;

        // halt: stays dark until Clear
        fetch("halt", 5'b11011, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step("halt_hold", '0);
        end
        clear = 1'b1;
        @(negedge clk);
        check_eq("halt_clear", ctl, '0);
        clear = 1'b0;
        ir_op = 5'b00011;
        step("restart_t0", F0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
